// File: rtl/pulse_meter_pkg.sv
// Shared constants for the pulse meter: FSM state encoding and default sizing.
package pulse_meter_pkg;

  localparam int CW_DEFAULT   = 8;
  localparam int SYNC_DEFAULT = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

endpackage

// File: rtl/pulse_meter_edge_sync.sv
// Brings the asynchronous pulse train into the clock domain and derives
// single-cycle rise/fall strobes from the synchronized level.
module edge_sync
  import pulse_meter_pkg::*;
#(
  parameter int SYNC = SYNC_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic signal,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC-1:0] chain;
  logic [SYNC-1:0] filled;
  logic            sp;
  logic            seenlow;

  // A level already high when reset is released must not look like a rise,
  // so rises are only accepted once a genuine low has come out of the chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain   <= '0;
      filled  <= '0;
      sp      <= 1'b0;
      seenlow <= 1'b0;
    end else begin
      chain  <= {chain[SYNC-2:0], signal};
      filled <= {filled[SYNC-2:0], 1'b1};
      sp     <= s;
      if (filled[SYNC-1] && !s) begin
        seenlow <= 1'b1;
      end
    end
  end

  assign s    = chain[SYNC-1];
  assign rise = s & ~sp & seenlow;
  assign fall = ~s & sp;

endmodule

// File: rtl/pulse_meter.sv
// Measures high time and rising-to-rising period of an asynchronous pulse
// train, with a sticky timeout flag when no period completes in time.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CW   = CW_DEFAULT,
  parameter int SYNC = SYNC_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          on,
  input  logic          signal,
  output logic [CW-1:0] width,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          ovf
);

  localparam logic [CW-1:0] PMAX = '1;
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          s;
  logic          rise;
  logic          fall;
  logic [1:0]    state;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] pcnt;

  edge_sync #(.SYNC(SYNC)) u_sync (
    .clock  (clock),
    .reset  (reset),
    .signal (signal),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  // The rise that starts a measurement counts as cycle 1 of the next period,
  // and the fall cycle belongs to the low phase, so width=H and period=H+L.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      hcnt   <= '0;
      pcnt   <= '0;
      width  <= '0;
      period <= '0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!on) begin
        state <= ST_IDLE;
        hcnt  <= '0;
        pcnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            hcnt  <= '0;
            pcnt  <= '0;
            state <= ST_ARM;
          end
          ST_ARM: begin
            if (rise) begin
              hcnt  <= ONE;
              pcnt  <= ONE;
              state <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (pcnt == PMAX) begin
              ovf   <= 1'b1;
              hcnt  <= '0;
              pcnt  <= '0;
              state <= ST_ARM;
            end else if (fall) begin
              pcnt  <= pcnt + ONE;
              state <= ST_LOW;
            end else if (s) begin
              pcnt <= pcnt + ONE;
              hcnt <= hcnt + ONE;
            end
          end
          default: begin
            // A rise at the limit still completes a legal period before timing out.
            if (rise) begin
              width  <= hcnt;
              period <= pcnt;
              valid  <= 1'b1;
              ovf    <= 1'b0;
              hcnt   <= ONE;
              pcnt   <= ONE;
              state  <= ST_HIGH;
            end else if (pcnt == PMAX) begin
              ovf   <= 1'b1;
              hcnt  <= '0;
              pcnt  <= '0;
              state <= ST_ARM;
            end else begin
              pcnt <= pcnt + ONE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 Parameter: CW, 8, bit width of the width/period counters and outputs.
REQ-002 Parameter: SYNC, 2, number of input synchronizer flops (legal values 2..3).
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: on  input  1  measurement enable; sampled synchronously.
REQ-006 Port: signal  input  1  asynchronous pulse train to be measured.
REQ-007 Port: width  output  CW  high time of last complete pulse, in clock cycles.
REQ-008 Port: period  output  CW  rising-to-rising time of last complete pulse, in clock cycles.
REQ-009 Port: valid  output  1  one-cycle strobe; width/period updated this cycle.
REQ-010 Port: ovf  output  1  timeout flag; no complete period within 2^CW-1 cycles.

Function
REQ-011 signal SHALL pass through SYNC flops; s = last synchronizer stage; sp = s delayed one cycle; rise = s & ~sp; fall = ~s & sp.
REQ-012 FSM states SHALL be IDLE, ARM, HIGH, LOW.
REQ-013 IDLE: counters cleared; on=1 -> ARM.
REQ-014 ARM: wait for rise; on rise -> HIGH, pcnt=1, hcnt=1.
REQ-015 HIGH: pcnt+1 and hcnt+1 each cycle with s=1; fall -> LOW (hcnt frozen).
REQ-016 LOW: pcnt+1 each cycle; on rise -> width<=hcnt, period<=pcnt, valid=1 next cycle, ovf<=0; restart pcnt=1, hcnt=1; stay measuring (-> HIGH).
REQ-017 Result: signal high H cycles, low L cycles (as seen at s) SHALL give width=H, period=H+L.
REQ-018 valid SHALL be high exactly one cycle per completed period; latency from rise at s to valid = 1 cycle.
REQ-019 If pcnt reaches 2^CW-1 in HIGH or LOW without completing a period: ovf<=1 (sticky), valid not asserted, width/period hold, FSM -> ARM.
REQ-020 ovf SHALL clear only on the next valid or on reset.
REQ-021 on=0 in any state SHALL force IDLE next cycle; width/period/ovf hold; valid=0; a partial measurement is discarded.
REQ-022 Rise and on=0 in the same cycle: on=0 wins, no valid.
REQ-023 Counter arithmetic SHALL be unsigned CW bits; no wrap (overflow path above catches the limit).
REQ-024 A pulse whose first rise occurs before on=1 is detected SHALL NOT be measured; the first measured period starts at the first rise seen in ARM.

Reset
REQ-025 reset=1 SHALL asynchronously force: state IDLE, synchronizer flops and sp=0, hcnt=pcnt=0, width=0, period=0, valid=0, ovf=0.
REQ-026 Reset released mid-pulse (signal=1): the existing high level SHALL NOT count as a rise until signal goes low then high.
REQ-027 Reset asserted mid-measurement SHALL discard it, with no valid.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, ARM=1, HIGH=2, LOW=3) and default CW/SYNC constants.
REQ-029 The synchronizer plus edge detector SHALL be a sub-module named edge_sync (outputs s, rise, fall).
REQ-030 The remainder (FSM, counters, output registers) SHALL stay in pulse_meter; target 150-250 RTL lines.

Verification
REQ-031 Reset, on=1, signal 3 cycles high / 3 low, repeated 4x -> valid pulses 3x (first rise only arms), each with width=3, period=6, ovf=0.
REQ-032 Duty change: 5 high / 2 low, then 1 high / 9 low -> valids report (5,7), then (1,10).
REQ-033 CW=8, signal held low 300 cycles after one rise -> ovf=1 at pcnt=255, no valid, width/period unchanged; next two rises 4 apart with 2 high -> valid, (2,4), ovf=0.
REQ-034 on dropped to 0 in LOW mid-period, raised 5 cycles later -> no valid for the aborted period; next full period is measured correctly.
REQ-035 Reset asserted asynchronously between clock edges while in HIGH -> all outputs 0 immediately; after release with signal already high -> no rise detected until a low-to-high transition.
REQ-036 Glitch-free check: signal toggled asynchronously to clock (33-unit half-period vs 3-unit pulse steps) -> valid never lasts more than 1 cycle, and width < period for every valid.
